// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg: shared encodings for the GPIO APB arbiter.
// FSM states, byte-strobe values and the APB address width.
package gpio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  localparam logic [3:0] PSTB_WR = 4'hF;
  localparam logic [3:0] PSTB_RD = 4'h0;
  localparam int         APB_AW  = 32;

endpackage

// File: rtl/gpio_apb_arbiter_if.sv
// gpio_apb_arbiter_if: requester and APB signals of the arbiter.
// master = arbiter view, slave = requesters plus GPIO slave view.
interface gpio_apb_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 8
) ();
  import gpio_arb_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*32-1:0]     req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [31:0]             rsp_rdata;
  logic                    rsp_err;
  logic                    busy;
  logic [APB_AW-1:0]       apb_addr;
  logic                    apb_sel;
  logic                    apb_ena;
  logic                    apb_write;
  logic [31:0]             apb_wdata;
  logic [3:0]              apb_pstb;
  logic [31:0]             apb_rdata;
  logic                    apb_rready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  apb_rdata, apb_rready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output apb_addr, apb_sel, apb_ena, apb_write,
    output apb_wdata, apb_pstb
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output apb_rdata, apb_rready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  apb_addr, apb_sel, apb_ena, apb_write,
    input  apb_wdata, apb_pstb
  );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
// Search starts just after last_i, wraps, first set bit wins.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // walk the ring once, lowest priority is the last winner
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if ((gnt_o == '0) &&
          req_i[(int'(last_i) + i) % N_REQ]) begin
        gnt_o[(int'(last_i) + i) % N_REQ] = 1'b1;
        idx_o = IDX_W'((int'(last_i) + i) % N_REQ);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/gpio_apb_arbiter.sv
// gpio_apb_arbiter: round-robin share of the GPIO APB slave port.
// Serialises single requests into SETUP/ACCESS with a watchdog abort.
module gpio_apb_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               rst,
  gpio_apb_arbiter_if.master bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  req_ready_q, req_ready_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;
  logic [APB_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [3:0]        pstb_q, pstb_d;
  logic              sel_q, sel_d;
  logic              ena_q, ena_d;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              timeout_hit;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i  (bus.req_valid),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    pstb_d      = pstb_q;
    sel_d       = sel_q;
    ena_d       = ena_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = SETUP;
          last_d      = pick_idx;
          cnt_d       = '0;
          req_ready_d = pick_gnt;
          addr_d      = APB_AW'(
            bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W]);
          wdata_d     = bus.req_wdata[int'(pick_idx)*32 +: 32];
          write_d     = bus.req_write[pick_idx];
          pstb_d      = bus.req_write[pick_idx] ? PSTB_WR
                                                : PSTB_RD;
          sel_d       = 1'b1;
          ena_d       = 1'b0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        ena_d   = 1'b1;
      end
      ACCESS: begin
        if (bus.apb_rready) begin
          state_d             = IDLE;
          rsp_valid_d[last_q] = 1'b1;
          rsp_rdata_d         = write_q ? '0 : bus.apb_rdata;
          sel_d               = 1'b0;
          ena_d               = 1'b0;
        end else if (timeout_hit) begin
          state_d             = IDLE;
          rsp_valid_d[last_q] = 1'b1;
          rsp_err_d           = 1'b1;
          sel_d               = 1'b0;
          ena_d               = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers, synchronous reset
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= LAST_RST;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      pstb_q      <= '0;
      sel_q       <= 1'b0;
      ena_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      pstb_q      <= pstb_d;
      sel_q       <= sel_d;
      ena_q       <= ena_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
  assign bus.apb_addr  = addr_q;
  assign bus.apb_sel   = sel_q;
  assign bus.apb_ena   = ena_q;
  assign bus.apb_write = write_q;
  assign bus.apb_wdata = wdata_q;
  assign bus.apb_pstb  = pstb_q;

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// tb_gpio_apb_arbiter: random requesters and APB slave against
// a transaction-timeline reference model of the arbiter.
module tb_gpio_apb_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int TO = 16;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  gpio_apb_arbiter_if #(.N_REQ(N), .ADDR_W(AW)) bus ();

  gpio_apb_arbiter #(
    .N_REQ   (N),
    .ADDR_W  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic          d_valid [N];
  logic          d_write [N];
  logic [AW-1:0] d_addr  [N];
  logic [31:0]   d_wdata [N];

  logic [31:0] ref_mem [256];
  logic [31:0] slv_mem [256];

  bit          t_act = 1'b0;
  int          t_g, t_ready, t_resp;
  bit          t_to, t_write;
  logic [AW-1:0] t_addr;
  logic [31:0] t_wdata;
  int          m_last  = N - 1;
  int          force_w = -1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, want %h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] oh(input int i);
    oh = 32'd1 << i;
  endfunction

  function automatic bit pend();
    pend = 1'b0;
    for (int i = 0; i < N; i++)
      if (d_valid[i]) pend = 1'b1;
  endfunction

  task automatic observe();
    bit xfer, acc;
    @(negedge clock);
    cyc++;
    xfer = t_act && cyc >= t_ready && cyc < t_resp;
    acc  = t_act && cyc >  t_ready && cyc < t_resp;
    chk("req_ready", 32'(bus.req_ready),
        (t_act && cyc == t_ready) ? oh(t_g) : 32'd0);
    chk("apb_sel", 32'(bus.apb_sel), 32'(xfer));
    chk("apb_ena", 32'(bus.apb_ena), 32'(acc));
    chk("busy", 32'(bus.busy), 32'(xfer));
    if (xfer) begin
      chk("apb_addr", bus.apb_addr, 32'(t_addr));
      chk("apb_write", 32'(bus.apb_write), 32'(t_write));
      chk("apb_pstb", 32'(bus.apb_pstb),
          t_write ? 32'hF : 32'h0);
      if (t_write) chk("apb_wdata", bus.apb_wdata, t_wdata);
    end
    if (t_act && cyc == t_resp) begin
      chk("rsp_valid", 32'(bus.rsp_valid), oh(t_g));
      chk("rsp_err", 32'(bus.rsp_err), 32'(t_to));
      chk("rsp_rdata", bus.rsp_rdata,
          (t_to || t_write) ? 32'd0 : ref_mem[t_addr]);
      if (t_write && !t_to) ref_mem[t_addr] = t_wdata;
      t_act = 1'b0;
    end else begin
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  task automatic drive(input int p_new);
    bit acc, fin;
    int g, j, w, r;
    for (int i = 0; i < N; i++) begin
      if (bus.req_ready[i]) d_valid[i] = 1'b0;
      if (!d_valid[i] && $urandom_range(99) < p_new) begin
        d_valid[i] = 1'b1;
        d_write[i] = 1'($urandom_range(1));
        d_addr[i]  = AW'($urandom_range(15));
        d_wdata[i] = $urandom;
      end
      bus.req_valid[i]            = d_valid[i];
      bus.req_write[i]            = d_write[i];
      bus.req_addr[i*AW +: AW]    = d_addr[i];
      bus.req_wdata[i*32 +: 32]   = d_wdata[i];
    end
    acc = t_act && cyc > t_ready && cyc < t_resp;
    fin = acc && !t_to && cyc == t_resp - 1;
    bus.apb_rready = fin ? 1'b1 :
                     acc ? 1'b0 : 1'($urandom_range(1));
    bus.apb_rdata  = fin ? slv_mem[bus.apb_addr[AW-1:0]]
                         : $urandom;
    if (fin && bus.apb_write)
      slv_mem[bus.apb_addr[AW-1:0]] = bus.apb_wdata;
    if (!t_act) begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (g < 0 && d_valid[j]) g = j;
      end
      if (g >= 0) begin
        r = int'($urandom_range(99));
        if (force_w >= 0) w = force_w;
        else if (r < 60) w = 0;
        else if (r < 92) w = int'($urandom_range(4, 1));
        else w = TO + 1;
        t_act   = 1'b1;
        t_g     = g;
        m_last  = g;
        t_ready = cyc + 1;
        t_to    = (w >= TO);
        t_resp  = t_to ? cyc + 2 + TO : cyc + 3 + w;
        t_write = d_write[g];
        t_addr  = d_addr[g];
        t_wdata = d_wdata[g];
      end
    end
  endtask

  task automatic step(input int p_new);
    observe();
    drive(p_new);
  endtask

  task automatic drain();
    int b = 0;
    do begin
      step(0);
      b++;
    end while ((t_act || pend()) && b < 100);
    chk("drain_idle", 32'(t_act || pend()), 32'd0);
  endtask

  task automatic req(input int i, input bit wr,
                     input logic [AW-1:0] a,
                     input logic [31:0] d);
    d_valid[i] = 1'b1;
    d_write[i] = wr;
    d_addr[i]  = a;
    d_wdata[i] = d;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_rvld"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_sel"}, 32'(bus.apb_sel), 32'd0);
    chk({tag, "_ena"}, 32'(bus.apb_ena), 32'd0);
    chk({tag, "_addr"}, bus.apb_addr, 32'd0);
    chk({tag, "_write"}, 32'(bus.apb_write), 32'd0);
    chk({tag, "_wdata"}, bus.apb_wdata, 32'd0);
    chk({tag, "_pstb"}, 32'(bus.apb_pstb), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int b;
    for (int a = 0; a < 256; a++) begin
      ref_mem[a] = $urandom;
      slv_mem[a] = ref_mem[a];
    end
    for (int i = 0; i < N; i++) begin
      d_valid[i] = 1'b0;
      d_write[i] = 1'b0;
      d_addr[i]  = '0;
      d_wdata[i] = '0;
    end
    bus.req_valid  = '0;
    bus.req_write  = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.apb_rready = 1'b0;
    bus.apb_rdata  = '0;

    rst = 1'b1;
    repeat (3) @(negedge clock);
    chk_reset_outs("rst");
    rst = 1'b0;

    force_w = 0;
    drive(100);
    repeat (12) step(100);
    drain();

    ref_mem[4] = 32'h000A_BCDE;
    slv_mem[4] = 32'h000A_BCDE;
    req(0, 1'b0, 8'h04, 32'h0);
    drain();
    req(1, 1'b1, 8'h0C, 32'h0001_2345);
    drain();
    req(0, 1'b0, 8'h0C, 32'h0);
    drain();

    force_w = 3;
    req(1, 1'b0, 8'h04, 32'h0);
    drain();

    force_w = TO + 4;
    req(0, 1'b1, 8'h05, 32'hDEAD_BEEF);
    drain();
    force_w = 0;
    req(1, 1'b0, 8'h05, 32'h0);
    drain();

    force_w = -1;
    repeat (3000) step(35);
    drain();

    force_w = 12;
    req(1, 1'b0, 8'h07, 32'h0);
    b = 0;
    do begin
      step(0);
      b++;
    end while (!(t_act && cyc == t_ready + 2) && b < 20);
    chk("mid_reach", 32'(t_act && cyc == t_ready + 2), 32'd1);
    rst = 1'b1;
    @(negedge clock);
    cyc++;
    chk_reset_outs("mid");
    t_act  = 1'b0;
    m_last = N - 1;
    rst    = 1'b0;
    force_w = 0;
    req(0, 1'b0, 8'h03, 32'h0);
    req(1, 1'b1, 8'h09, 32'h0BAD_F00D);
    drive(0);
    chk("mid_first_g", 32'(t_g), 32'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
